zero_one_event_counter: RTL and testbench
=========================================

// Module: zero_one_event_counter
// PURPOSE
//   Downstream consumer of the "01" sequence detector's one-cycle pulse output.
//   Counts detection pulses over fixed, back-to-back windows of WINDOW cycles.
//   Each window's count goes out through a one-entry valid/ready report buffer.
//   Flags saturation and reports that were lost to backpressure.
// PARAMETERS
//   WINDOW  16  cycles per counting window (>= 2); window counter width = $clog2(WINDOW)
//   CNT_W   8   width of the detection count; saturates at 2**CNT_W-1
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst        in   1      asynchronous, active-low reset (0 = reset)
//   en         in   1      windowing enable; sampled on clk
//   det        in   1      detection pulse from the sequence detector (Y)
//   rpt_ready  in   1      downstream accepts the report when high with rpt_valid
//   rpt_valid  out  1      report register holds an unconsumed report
//   rpt_count  out  CNT_W  detections in the reported window
//   rpt_sat    out  1      count saturated during the reported window
//   rpt_drop   out  1      >=1 earlier window result discarded since the last loaded report
//   busy       out  1      high while in COUNT
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, win_cnt=0, acc=0, acc_sat=0, drop_pend=0.
//     All outputs 0. A pending report is lost. Reset mid-window aborts the window silently.
//   FSM, 2 states:
//     IDLE : en=1 at an edge -> COUNT with win_cnt=0, acc=0, acc_sat=0; else stay.
//     COUNT: each edge samples det. acc += det, saturating: at max, acc holds and acc_sat=1.
//       win_cnt increments. en=0 at an edge -> IDLE, partial window discarded
//       (acc, win_cnt, acc_sat cleared), report buffer and drop_pend untouched.
//   Window end: the edge with win_cnt==WINDOW-1 and en=1.
//     That edge's det is included in the result.
//     win_cnt wraps to 0; acc/acc_sat restart at 0, so the next window begins with no gap.
//   Report load at window end:
//     Buffer free, or rpt_valid&rpt_ready on the same edge: load.
//       rpt_count = final acc (incl. last det), rpt_sat = final sat, rpt_drop = drop_pend.
//       rpt_valid=1, drop_pend cleared.
//     Buffer occupied and not accepted that edge: new result discarded, drop_pend=1.
//   Handshake: transfer on an edge with rpt_valid&rpt_ready.
//     rpt_count/sat/drop stay stable while rpt_valid=1 and not accepted.
//     Accept without load -> rpt_valid=0 next cycle; report fields hold their last value.
//     rpt_ready is ignored while rpt_valid=0.
//   Latency: en rising at edge E0. Samples det at E1..E_WINDOW.
//     rpt_valid is high in the cycle after E_WINDOW.
//   busy = (state==COUNT), registered, no combinational paths input->output.
// TESTING
//   1 Reset: assert rst=0 mid-operation with rpt_valid=1 -> all outputs 0 immediately;
//     rst=1, en=0 -> outputs stay 0.
//   2 Basic (WINDOW=16, CNT_W=8): en=1, det pulses on 3 of E1..E16, rpt_ready=1 ->
//     rpt_valid 1 cycle after E16, rpt_count=3, rpt_sat=0, rpt_drop=0; back-to-back windows report.
//   3 Saturation (CNT_W=3): det=1 every cycle for a window -> rpt_count=7, rpt_sat=1;
//     next window with 2 pulses -> count=2, sat=0.
//   4 Backpressure: rpt_ready=0 over windows with 2, then 5 detections -> report holds count=2;
//     raise ready -> accepted. Next window with 1 detection -> count=1, drop=1.
//   5 Accept+load same edge: rpt_ready=1 only on the window-end edge with report pending ->
//     rpt_valid stays 1, new count appears, rpt_drop=0.
//   6 Abort: en=0 after E8 with 4 detections -> busy=0 next cycle, no report.
//     Re-enable -> fresh full window reports only its own detections.

Source files
------------

// File: rtl/zero_one_event_counter.sv
// ----------------------------------------------------------------------------
// zero_one_event_counter
//   Counts one-cycle detection pulses from the "01" sequence detector over
//   back-to-back windows of WINDOW cycles. It offers each window's result
//   through a one-entry valid/ready report buffer. The count saturates at
//   2**CNT_W-1, and that condition is flagged. When a result finds the buffer
//   still occupied, the result is discarded and noted in the next report that
//   does get loaded.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous reset, active low (0 = reset)
//   en         in   1      windowing enable
//   det        in   1      detection pulse
//   rpt_ready  in   1      downstream accepts the report while rpt_valid=1
//   rpt_valid  out  1      report buffer holds an unconsumed report
//   rpt_count  out  CNT_W  detections counted in the reported window
//   rpt_sat    out  1      count saturated during the reported window
//   rpt_drop   out  1      at least one earlier result was discarded
//   busy       out  1      counting a window (state COUNT)
// ----------------------------------------------------------------------------
module zero_one_event_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_drop,
    output logic             busy
);

    localparam int                WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   r_acc;
    logic               r_acc_sat;
    logic               r_drop_pend;
    logic               r_rpt_valid;
    logic [CNT_W-1:0]   r_rpt_count;
    logic               r_rpt_sat;
    logic               r_rpt_drop;

    state_t             w_state_nxt;
    logic [WIN_W-1:0]   w_win_nxt;
    logic [CNT_W-1:0]   w_acc_nxt;
    logic               w_sat_nxt;
    logic [CNT_W-1:0]   w_acc_step;
    logic               w_sat_step;
    logic               w_win_end;
    logic               w_load;
    logic               w_drop_pend_nxt;
    logic               w_rpt_valid_nxt;
    logic [CNT_W-1:0]   w_rpt_count_nxt;
    logic               w_rpt_sat_nxt;
    logic               w_rpt_drop_nxt;

    // Accumulator after this edge's det: saturating add, sticky saturation flag
    always_comb begin
        w_acc_step = r_acc;
        w_sat_step = r_acc_sat;
        if (det) begin
            if (r_acc == CNT_MAX) begin
                w_sat_step = 1'b1;
            end else begin
                w_acc_step = r_acc + CNT_ONE;
            end
        end else begin
            w_acc_step = r_acc;
        end
    end

    // Window end includes this edge's det; a load is possible when the buffer
    // is free or is being emptied on the same edge
    always_comb begin
        w_win_end = (r_state == ST_COUNT) && en && (r_win_cnt == WIN_LAST);
        w_load    = w_win_end && (!r_rpt_valid || rpt_ready);
    end

    // Next-state and window bookkeeping
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_cnt;
        w_acc_nxt   = r_acc;
        w_sat_nxt   = r_acc_sat;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_COUNT;
                    w_win_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (!en) begin
                    // Abort: partial window is discarded, report side untouched
                    w_state_nxt = ST_IDLE;
                    w_win_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_sat_nxt   = 1'b0;
                end else if (w_win_end) begin
                    // Next window starts on the following edge with no gap
                    w_win_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_win_nxt   = r_win_cnt + WIN_ONE;
                    w_acc_nxt   = w_acc_step;
                    w_sat_nxt   = w_sat_step;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_win_nxt   = '0;
                w_acc_nxt   = '0;
                w_sat_nxt   = 1'b0;
            end
        endcase
    end

    // Report buffer: load, drop-on-full, or plain handshake consumption
    always_comb begin
        w_rpt_valid_nxt = r_rpt_valid;
        w_rpt_count_nxt = r_rpt_count;
        w_rpt_sat_nxt   = r_rpt_sat;
        w_rpt_drop_nxt  = r_rpt_drop;
        w_drop_pend_nxt = r_drop_pend;
        if (w_load) begin
            w_rpt_valid_nxt = 1'b1;
            w_rpt_count_nxt = w_acc_step;
            w_rpt_sat_nxt   = w_sat_step;
            w_rpt_drop_nxt  = r_drop_pend;
            w_drop_pend_nxt = 1'b0;
        end else if (w_win_end) begin
            // Buffer occupied and not accepted this edge: result is lost
            w_drop_pend_nxt = 1'b1;
        end else if (r_rpt_valid && rpt_ready) begin
            w_rpt_valid_nxt = 1'b0;
        end else begin
            w_rpt_valid_nxt = r_rpt_valid;
        end
    end

    // State, window and report registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_drop_pend <= 1'b0;
            r_rpt_valid <= 1'b0;
            r_rpt_count <= '0;
            r_rpt_sat   <= 1'b0;
            r_rpt_drop  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_cnt   <= w_win_nxt;
            r_acc       <= w_acc_nxt;
            r_acc_sat   <= w_sat_nxt;
            r_drop_pend <= w_drop_pend_nxt;
            r_rpt_valid <= w_rpt_valid_nxt;
            r_rpt_count <= w_rpt_count_nxt;
            r_rpt_sat   <= w_rpt_sat_nxt;
            r_rpt_drop  <= w_rpt_drop_nxt;
        end
    end

    assign rpt_valid = r_rpt_valid;
    assign rpt_count = r_rpt_count;
    assign rpt_sat   = r_rpt_sat;
    assign rpt_drop  = r_rpt_drop;
    assign busy      = (r_state == ST_COUNT);

endmodule

// File: tb/tb_zero_one_event_counter.sv
// ----------------------------------------------------------------------------
// tb_zero_one_event_counter
//   Directed bench. Two instances share every input: a default one
//   (WINDOW=16, CNT_W=8) and a narrow one (CNT_W=3) for saturation. Inputs
//   are driven 1 time unit after each rising edge, and outputs are sampled
//   at the same point.
// ----------------------------------------------------------------------------
module tb_zero_one_event_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       det;
    logic       rpt_ready;

    logic       m_valid;
    logic [7:0] m_count;
    logic       m_sat;
    logic       m_drop;
    logic       m_busy;

    logic       s_valid;
    logic [2:0] s_count;
    logic       s_sat;
    logic       s_drop;
    logic       s_busy;

    int n_checks;
    int n_errors;

    zero_one_event_counter #(.WINDOW(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .det(det), .rpt_ready(rpt_ready),
        .rpt_valid(m_valid), .rpt_count(m_count), .rpt_sat(m_sat),
        .rpt_drop(m_drop), .busy(m_busy)
    );

    zero_one_event_counter #(.WINDOW(16), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .en(en), .det(det), .rpt_ready(rpt_ready),
        .rpt_valid(s_valid), .rpt_count(s_count), .rpt_sat(s_sat),
        .rpt_drop(s_drop), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n cycles; cycle i uses det_pat[i] and rdy_pat[i]
    task automatic run_cycles(input logic [15:0] det_pat, input logic [15:0] rdy_pat, input int n);
        for (int i = 0; i < n; i++) begin
            det       = det_pat[i];
            rpt_ready = rdy_pat[i];
            tick();
        end
        det       = 1'b0;
        rpt_ready = 1'b0;
    endtask

    task automatic go_idle();
        en        = 1'b0;
        det       = 1'b0;
        rpt_ready = 1'b1;
        tick();
        tick();
        rpt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; det = 1'b0; rpt_ready = 1'b0;
        #3;
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop, m_busy} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_initial: got %h expected 000", {m_valid, m_count, m_sat, m_drop, m_busy});
        end
        tick();
        rst = 1'b1;
        tick();
        en = 1'b1;
        tick();
        run_cycles(16'h0003, 16'h0000, 16);
        n_checks++;
        if ({m_valid, m_count} !== {1'b1, 8'd2}) begin
            n_errors++;
            $display("FAIL reset_prefill: got v=%0b c=%0d expected v=1 c=2", m_valid, m_count);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop, m_busy, s_valid, s_count, s_sat, s_drop, s_busy} !== 20'h00000) begin
            n_errors++;
            $display("FAIL reset_async: got m=%h s=%h expected 0",
                     {m_valid, m_count, m_sat, m_drop, m_busy}, {s_valid, s_count, s_sat, s_drop, s_busy});
        end
        rst = 1'b1;
        en  = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop, m_busy} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected 000", {m_valid, m_count, m_sat, m_drop, m_busy});
        end
    endtask

    task automatic test_basic();
        go_idle();
        en = 1'b1;
        tick();
        n_checks++;
        if ({m_busy, m_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL basic_start: got busy=%0b valid=%0b expected busy=1 valid=0", m_busy, m_valid);
        end
        run_cycles(16'h0021, 16'hFFFF, 15);
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_early: got valid=%0b expected 0 before E16", m_valid);
        end
        run_cycles(16'h0001, 16'h0001, 1);
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop} !== {1'b1, 8'd3, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL basic_report: got v=%0b c=%0d s=%0b d=%0b expected v=1 c=3 s=0 d=0",
                     m_valid, m_count, m_sat, m_drop);
        end
        n_checks++;
        if ({s_valid, s_count, s_sat} !== {1'b1, 3'd3, 1'b0}) begin
            n_errors++;
            $display("FAIL basic_narrow: got v=%0b c=%0d s=%0b expected v=1 c=3 s=0", s_valid, s_count, s_sat);
        end
        run_cycles(16'h9111, 16'hFFFF, 16);
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop} !== {1'b1, 8'd5, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL back_to_back: got v=%0b c=%0d s=%0b d=%0b expected v=1 c=5 s=0 d=0",
                     m_valid, m_count, m_sat, m_drop);
        end
    endtask

    task automatic test_saturation();
        go_idle();
        en = 1'b1;
        tick();
        run_cycles(16'hFFFF, 16'hFFFF, 16);
        n_checks++;
        if ({s_valid, s_count, s_sat, s_drop} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL sat_narrow: got v=%0b c=%0d s=%0b d=%0b expected v=1 c=7 s=1 d=0",
                     s_valid, s_count, s_sat, s_drop);
        end
        n_checks++;
        if ({m_count, m_sat} !== {8'd16, 1'b0}) begin
            n_errors++;
            $display("FAIL sat_wide: got c=%0d s=%0b expected c=16 s=0", m_count, m_sat);
        end
        run_cycles(16'h0410, 16'hFFFF, 16);
        n_checks++;
        if ({s_valid, s_count, s_sat, s_drop} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL sat_clear: got v=%0b c=%0d s=%0b d=%0b expected v=1 c=2 s=0 d=0",
                     s_valid, s_count, s_sat, s_drop);
        end
    endtask

    task automatic test_backpressure();
        go_idle();
        en = 1'b1;
        tick();
        run_cycles(16'h0201, 16'h0000, 16);
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop} !== {1'b1, 8'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL bp_first: got v=%0b c=%0d d=%0b expected v=1 c=2 d=0", m_valid, m_count, m_drop);
        end
        run_cycles(16'h1F00, 16'h0000, 16);
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop} !== {1'b1, 8'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL bp_hold: got v=%0b c=%0d d=%0b expected v=1 c=2 d=0", m_valid, m_count, m_drop);
        end
        run_cycles(16'h0000, 16'h0001, 1);
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_accept: got valid=%0b expected 0", m_valid);
        end
        run_cycles(16'h0100, 16'h0000, 15);
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop} !== {1'b1, 8'd1, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL bp_drop: got v=%0b c=%0d d=%0b expected v=1 c=1 d=1", m_valid, m_count, m_drop);
        end
    endtask

    // Continues from the pending report left by test_backpressure
    task automatic test_accept_load();
        run_cycles(16'h000F, 16'h0000, 15);
        n_checks++;
        if ({m_valid, m_count, m_drop} !== {1'b1, 8'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL al_stable: got v=%0b c=%0d d=%0b expected v=1 c=1 d=1", m_valid, m_count, m_drop);
        end
        run_cycles(16'h0000, 16'h0001, 1);
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop} !== {1'b1, 8'd4, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL al_load: got v=%0b c=%0d d=%0b expected v=1 c=4 d=0", m_valid, m_count, m_drop);
        end
    endtask

    task automatic test_abort();
        go_idle();
        en = 1'b1;
        tick();
        run_cycles(16'h00AA, 16'h0000, 8);
        n_checks++;
        if ({m_busy, m_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL abort_mid: got busy=%0b valid=%0b expected busy=1 valid=0", m_busy, m_valid);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if ({m_busy, m_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL abort_idle: got busy=%0b valid=%0b expected 0 0", m_busy, m_valid);
        end
        tick(); tick(); tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_noreport: got valid=%0b expected 0", m_valid);
        end
        en = 1'b1;
        tick();
        run_cycles(16'h4002, 16'h0000, 15);
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_early: got valid=%0b expected 0", m_valid);
        end
        run_cycles(16'h0000, 16'h0000, 1);
        n_checks++;
        if ({m_valid, m_count, m_sat, m_drop} !== {1'b1, 8'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL abort_fresh: got v=%0b c=%0d s=%0b d=%0b expected v=1 c=2 s=0 d=0",
                     m_valid, m_count, m_sat, m_drop);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        en        = 1'b0;
        det       = 1'b0;
        rpt_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_accept_load();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
